// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - request/response and MMU bus bundle for mem_initiator
//
// Purpose: groups the core-side load/store handshake and the MMU-side
// access signals into one interface.
// Modports:
//   master - the initiator: drives req_ready, resp_*, mem_* outputs.
//   slave  - the environment: drives req_*, mem_rdata, mem_ready.
// Signals:
//   req_valid/req_ready, req_write, req_signed, req_width[1:0], req_addr, req_wdata
//   resp_valid, resp_rdata, resp_error
//   mem_read_enable, mem_write_enable, mem_signed_read, mem_data_width[1:0],
//   mem_address, mem_wdata, mem_rdata, mem_ready
interface mem_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_signed;
    logic [1:0]            req_width;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic                  mem_signed_read;
    logic [1:0]            mem_data_width;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        input  req_valid, req_write, req_signed, req_width, req_addr, req_wdata,
        input  mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read_enable, mem_write_enable, mem_signed_read,
        output mem_data_width, mem_address, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_signed, req_width, req_addr, req_wdata,
        output mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read_enable, mem_write_enable, mem_signed_read,
        input  mem_data_width, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - load/store master driving the MMU enable/mem_ready handshake
//
// Purpose: accepts one load/store at a time, checks alignment, runs a single
// MMU access (ISSUE, WAIT, GAP) and returns a one-cycle response.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - mem_initiator_if.master (request, response and MMU signals)
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT lasting
// TIMEOUT_CYCLES cycles with an error response.
module mem_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    mem_initiator_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_error;
    logic                  r_mem_read_enable;
    logic                  r_mem_write_enable;
    logic                  r_mem_signed_read;
    logic [1:0]            r_mem_data_width;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_write;
    logic                  w_misaligned;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_timer;
`else
    // keeps TIMEOUT_CYCLES referenced when the timeout counter is compiled out
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // width 2'b11 has no legal encoding, so it is rejected like a misaligned access
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_width)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = bus.req_addr[0];
            2'b10:   w_misaligned = |bus.req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_req_ready        <= 1'b1;
            r_resp_valid       <= 1'b0;
            r_resp_rdata       <= '0;
            r_resp_error       <= 1'b0;
            r_mem_read_enable  <= 1'b0;
            r_mem_write_enable <= 1'b0;
            r_mem_signed_read  <= 1'b0;
            r_mem_data_width   <= 2'b00;
            r_mem_address      <= '0;
            r_mem_wdata        <= '0;
            r_write            <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_timer            <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_write     <= bus.req_write;
                        if (w_misaligned) begin
                            // no MMU access: answer with an error straight away
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_state            <= S_ISSUE;
                            r_mem_read_enable  <= ~bus.req_write;
                            r_mem_write_enable <= bus.req_write;
                            r_mem_signed_read  <= bus.req_signed & ~bus.req_write;
                            r_mem_data_width   <= bus.req_width;
                            r_mem_address      <= bus.req_addr;
                            r_mem_wdata        <= bus.req_wdata;
`ifdef MEM_TIMEOUT_EN
                            r_timer            <= '0;
`endif
                        end
                    end
                end
                // mem_ready still shows the MMU's pre-request idle state here
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        if (!r_write) begin
                            r_resp_rdata <= bus.mem_rdata;
                        end
                        r_mem_read_enable  <= 1'b0;
                        r_mem_write_enable <= 1'b0;
                        r_state            <= S_GAP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_timer == TIMER_LAST) begin
                        r_resp_error       <= 1'b1;
                        r_mem_read_enable  <= 1'b0;
                        r_mem_write_enable <= 1'b0;
                        r_state            <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
                // enables are already low here, giving the MMU an idle cycle
                S_GAP: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready        = r_req_ready;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_rdata       = r_resp_rdata;
    assign bus.resp_error       = r_resp_error;
    assign bus.mem_read_enable  = r_mem_read_enable;
    assign bus.mem_write_enable = r_mem_write_enable;
    assign bus.mem_signed_read  = r_mem_signed_read;
    assign bus.mem_data_width   = r_mem_data_width;
    assign bus.mem_address      = r_mem_address;
    assign bus.mem_wdata        = r_mem_wdata;
endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Load/store master that drives the MMU request interface on behalf of the CPU pipeline.
- Accepts one load/store request at a time on a valid/ready port.
- Runs the MMU enable/mem_ready handshake and returns read data or an error response.
- Sits between the core's memory stage and the mmu instance. It is the initiator for which the MMU is the responder.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_address.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 255, WAIT cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1=store, 0=load.
- req_signed  in  1  sign-extend load result.
- req_width  in  2  MMU_WIDTH_BYTE=2'b00, MMU_WIDTH_HALF=2'b01, MMU_WIDTH_WORD=2'b10 (define.v).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: misaligned access or timeout.
- mem_read_enable  out  1  to mmu read_enable.
- mem_write_enable  out  1  to mmu write_enable.
- mem_signed_read  out  1  to mmu mem_signed_read.
- mem_data_width  out  2  to mmu mem_data_width.
- mem_address  out  ADDR_WIDTH  to mmu address.
- mem_wdata  out  DATA_WIDTH  to mmu data_in.
- mem_rdata  in  DATA_WIDTH  from mmu data_out.
- mem_ready  in  1  from mmu; high = current access complete / MMU idle.

Behaviour:
- Reset values:
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0.
  - All mem_* outputs 0.
  - Timeout counter 0.
- Reset mid-operation aborts immediately. No response is produced and enables drop on the next edge.
- States: IDLE, ISSUE, WAIT, GAP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, signed, width, addr and wdata.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0; width 2'b11 is treated as misaligned) → RESP with resp_error=1. No MMU access is issued.
  - Otherwise → ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert mem_read_enable or mem_write_enable (never both).
  - mem_address, mem_data_width, mem_signed_read and mem_wdata are driven from the latched values.
  - mem_ready is ignored this cycle because it reflects the pre-request state.
  - → WAIT.
- WAIT:
  - Enable and all mem_* outputs are held stable.
  - On mem_ready=1, capture mem_rdata (loads only) → GAP.
- GAP (1 cycle):
  - Enables deasserted, guaranteeing the MMU sees an idle cycle between accesses.
  - → RESP.
- RESP (1 cycle):
  - resp_valid=1; resp_rdata/resp_error hold the result.
  - → IDLE.
  - resp_rdata and resp_error return to 0 in IDLE.
- Latency:
  - Aligned access with mem_ready first high k cycles after ISSUE (k≥1): resp_valid rises k+3 cycles after the accept edge.
  - Misaligned access: resp_valid 1 cycle after accept.
- req_ready is 0 in every state except IDLE. A req_valid outside IDLE is ignored and must be held by the requester.
- Load data is passed through unchanged. Extension is performed by the MMU from mem_signed_read.
- mem_signed_read is forced to 0 for stores.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - The counter increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without mem_ready → GAP, then RESP with resp_error=1 and resp_rdata=0.
  - The counter clears on entering ISSUE.
- When undefined: no counter exists and WAIT waits indefinitely.

Test Plan:
- Reset: pulse reset for 2 cycles → req_ready=1, resp_valid=0, mem_read_enable=0, mem_write_enable=0.
- Word load: addr=0, width=WORD, unsigned; MMU model asserts mem_ready 3 cycles after ISSUE with mem_rdata=32'h00200293 → mem_read_enable high for ISSUE+WAIT cycles, resp_valid exactly 6 cycles after accept, resp_rdata=32'h00200293, resp_error=0.
- LED store: addr=32'h03000000, wdata=32'h69BABACA, WORD → mem_write_enable=1, mem_wdata=32'h69BABACA held until mem_ready; resp_valid with resp_rdata=0; mmu led=5'b01010.
- Misaligned: word load at 32'h01000002 → no enable ever asserted, resp_valid next cycle, resp_error=1; half at 32'h01000001 → same.
- Back-to-back: req_valid held high with two loads → second accepted only after RESP; at least one cycle of both enables low between the accesses.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8, mem_ready stuck 0 → resp_error=1 after ISSUE+8 WAIT+GAP cycles. Reset asserted during WAIT → enables 0 next cycle, no resp_valid.
